// File: rtl/nona_instr_dispatcher.sv
// rtl/nona_instr_dispatcher.sv - packet FIFO and one-per-cycle issue controller for the nine-core instruction port
// Optional feature macro: NONA_DISP_CORE_MASK_EN adds a per-core enable mask input.
module nona_instr_dispatcher #(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_CORES  = 9,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  in_core_id,
    input  logic [7:0]                  in_opcode,
    input  logic [7:0]                  in_op1,
    input  logic [7:0]                  in_op2,
    output logic [3:0]                  core_id,
    output logic [7:0]                  instruction,
    output logic [7:0]                  operand1,
    output logic [7:0]                  operand2,
    input  logic [7:0]                  result,
    input  logic                        resume,
    output logic                        halted,
    output logic                        redirect_valid,
    output logic [7:0]                  redirect_target,
    output logic [CNT_W-1:0]            issue_count,
    output logic [7:0]                  drop_count,
`ifdef NONA_DISP_CORE_MASK_EN
    input  logic [NUM_CORES-1:0]        core_enable_mask,
`endif
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int          AW   = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  NOP  = 8'h15;
    localparam logic [4:0]  NC   = 5'(NUM_CORES);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_WAIT_FLOW, S_WAIT_HLT, S_HALTED} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [27:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_wait;
    logic [27:0]   w_head;
    logic [3:0]    w_head_core;
    logic [7:0]    w_head_op;
    logic [15:0]   w_mask;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_pkt_ok;
    logic          w_issue;
    logic          w_drop;
    logic          w_flow_op;
    logic          w_hlt_op;
    logic          w_redirect;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_core = w_head[27:24];
    assign w_head_op   = w_head[23:16];
    assign w_full      = (r_count == FULL);
    assign in_ready    = ~w_full;
    assign fifo_level  = r_count;
    assign w_push      = in_valid & ~w_full;
    assign w_pop       = (r_state == S_RUN) && (r_count != '0);
    assign w_flow_op   = (w_head_op == 8'h0E) || (w_head_op == 8'h0F) ||
                         (w_head_op == 8'h10) || (w_head_op == 8'h13);
    assign w_hlt_op    = (w_head_op == 8'h14);

`ifdef NONA_DISP_CORE_MASK_EN
    assign w_mask = 16'(core_enable_mask);
`else
    assign w_mask = 16'hFFFF;
`endif
    assign w_pkt_ok = ({1'b0, w_head_core} < NC) && w_mask[w_head_core] && (w_head_op <= 8'h17);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_core_id, in_opcode, in_op1, in_op2};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // r_wait toggles once per wait cycle, so the second wait edge sees it set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
            r_wait  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= (r_state == S_WAIT_FLOW || r_state == S_WAIT_HLT) ? ~r_wait : 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_issue && w_flow_op)     w_state_nxt = S_WAIT_FLOW;
                else if (w_issue && w_hlt_op) w_state_nxt = S_WAIT_HLT;
            end
            S_WAIT_FLOW: if (r_wait) w_state_nxt = S_RUN;
            S_WAIT_HLT:  if (r_wait) w_state_nxt = (result == 8'hFF) ? S_HALTED : S_RUN;
            S_HALTED:    if (resume) w_state_nxt = S_RUN;
            default:     w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_issue    = w_pop & w_pkt_ok;
        w_drop     = w_pop & ~w_pkt_ok;
        w_redirect = (r_state == S_WAIT_FLOW) & r_wait;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_id         <= '0;
            instruction     <= NOP;
            operand1        <= '0;
            operand2        <= '0;
            halted          <= 1'b0;
            redirect_valid  <= 1'b0;
            redirect_target <= '0;
            issue_count     <= '0;
            drop_count      <= '0;
        end else begin
            core_id        <= w_issue ? w_head_core    : 4'd0;
            instruction    <= w_issue ? w_head_op      : NOP;
            operand1       <= w_issue ? w_head[15:8]   : 8'd0;
            operand2       <= w_issue ? w_head[7:0]    : 8'd0;
            halted         <= (w_state_nxt == S_HALTED);
            redirect_valid <= w_redirect;
            if (w_redirect) redirect_target <= result;
            if (w_issue) issue_count <= issue_count + 1'b1;
            if (w_drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
        end
    end
endmodule
